// File: rtl/irq_controller_vec.sv
// Vectored interrupt controller: level/edge request capture, masking, fixed
// lowest-index priority, per-channel mcause, and handler nesting tracking.
module irq_controller_vec #(
  parameter int unsigned N_IRQ      = 16,
  parameter logic [31:0] EDGE_MASK  = 32'h0,
  parameter logic [31:0] CAUSE_BASE = 32'h1000_0010,
  localparam int unsigned IDW       = $clog2(N_IRQ)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             exception_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  input  logic             mie_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [IDW-1:0]   irq_id_o,
  output logic             irq_ret_o,
  output logic [N_IRQ-1:0] pending_o
);

  typedef enum logic [1:0] {IDLE, IRQ, EXC, IRQ_EXC} state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] edge_mask;
  logic [N_IRQ-1:0] edge_pend_q, edge_pend_d;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending, eligible, grant_clr;
  logic [IDW-1:0]   winner;

  assign edge_mask = EDGE_MASK[N_IRQ-1:0];

  // Level channels pass straight through; gated by reset so pending reads 0 while held.
  assign pending   = rst_ni ? ((edge_pend_q & edge_mask) | (irq_req_i & ~edge_mask)) : '0;
  assign eligible  = pending & irq_mask_i;
  assign pending_o = pending;

  always_comb begin
    winner = '0;
    for (int unsigned k = N_IRQ; k > 0; k--) begin
      if (eligible[k-1]) winner = IDW'(k - 1);
    end
  end

  assign irq_o     = rst_ni & (state_q == IDLE) & mie_i & (|eligible) & ~exception_i;
  assign irq_ret_o = (state_q == IRQ) & mret_i & ~exception_i;

  // A fresh edge in the grant cycle overrides the clear, so it is not lost.
  assign grant_clr   = irq_o ? (edge_mask & (N_IRQ'(1) << winner)) : '0;
  assign edge_pend_d = ((edge_pend_q & ~grant_clr) | (irq_req_i & ~prev_q)) & edge_mask;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (exception_i) state_d = EXC;
        else if (irq_o)  state_d = IRQ;
      end
      EXC: begin
        if (mret_i) state_d = IDLE;
      end
      IRQ: begin
        if (exception_i) state_d = IRQ_EXC;
        else if (mret_i) state_d = IDLE;
      end
      IRQ_EXC: begin
        if (mret_i) state_d = IRQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      edge_pend_q <= '0;
      prev_q      <= '0;
      irq_id_o    <= '0;
      irq_cause_o <= CAUSE_BASE;
    end else begin
      state_q     <= state_d;
      edge_pend_q <= edge_pend_d;
      prev_q      <= irq_req_i;
      if (irq_o) begin
        irq_id_o    <= winner;
        irq_cause_o <= CAUSE_BASE + 32'(winner);
      end
    end
  end

endmodule

// File: tb/tb_irq_controller_vec.sv
// Scoreboard bench for irq_controller_vec: a stack-based handler model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_irq_controller_vec;
  localparam int unsigned N    = 16;
  localparam int unsigned IDW  = 4;
  localparam logic [31:0] EDGE = 32'h0000_F0A0;
  localparam logic [31:0] BASE = 32'h1000_0010;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           exc = 1'b0, mie = 1'b0, mret = 1'b0;
  logic [N-1:0]   req = '0, mask = '0;
  logic           irq, ret;
  logic [31:0]    cause;
  logic [IDW-1:0] id;
  logic [N-1:0]   pend;

  irq_controller_vec #(.N_IRQ(N), .EDGE_MASK(EDGE), .CAUSE_BASE(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .exception_i(exc), .irq_req_i(req),
    .irq_mask_i(mask), .mie_i(mie), .mret_i(mret), .irq_o(irq),
    .irq_cause_o(cause), .irq_id_o(id), .irq_ret_o(ret), .pending_o(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           irq;
    logic           ret;
    logic [N-1:0]   pend;
    logic [IDW-1:0] id;
    logic [31:0]    cause;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: handler nesting as a stack (1 = interrupt, 0 = exception).
  logic [N-1:0]   edge_v;
  logic [N-1:0]   m_epend, m_prev;
  bit             m_stack[$];
  logic [IDW-1:0] m_id;
  logic [31:0]    m_cause;

  function automatic logic [N-1:0] m_pending();
    if (!rst_n) return '0;
    return (m_epend & edge_v) | (req & ~edge_v);
  endfunction

  function automatic int m_winner(logic [N-1:0] el);
    for (int i = 0; i < int'(N); i++) if (el[i]) return i;
    return -1;
  endfunction

  function automatic bit m_grant();
    return rst_n && m_stack.size() == 0 && mie && !exc && m_winner(m_pending() & mask) >= 0;
  endfunction

  task automatic m_reset();
    m_epend = '0;
    m_prev  = '0;
    m_stack.delete();
    m_id    = '0;
    m_cause = BASE;
  endtask

  task automatic m_step();
    bit           g;
    int           w;
    logic [N-1:0] clr;
    if (!rst_n) begin
      m_reset();
      return;
    end
    g   = m_grant();
    w   = m_winner(m_pending() & mask);
    clr = '0;
    if (g) clr[w] = 1'b1;
    m_epend = ((m_epend & ~clr) | (req & ~m_prev)) & edge_v;
    m_prev  = req;
    if (m_stack.size() == 0) begin
      if (exc) m_stack.push_back(1'b0);
      else if (g) begin
        m_stack.push_back(1'b1);
        m_id    = w[IDW-1:0];
        m_cause = BASE + 32'(w);
      end
    end else if (m_stack[$] == 1'b0) begin
      if (mret) void'(m_stack.pop_back());
    end else begin
      if (exc) m_stack.push_back(1'b0);
      else if (mret) void'(m_stack.pop_back());
    end
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] q, input logic [N-1:0] mk,
                       input logic ie, input logic e, input logic mr);
    exp_t ex;
    @(posedge clk);
    #1;
    m_step();
    rst_n = r; req = q; mask = mk; mie = ie; exc = e; mret = mr;
    if (!rst_n) m_reset();
    ex.irq   = m_grant();
    ex.ret   = rst_n && m_stack.size() == 1 && m_stack[0] == 1'b1 && mret && !exc;
    ex.pend  = m_pending();
    ex.id    = m_id;
    ex.cause = m_cause;
    sb.push_back(ex);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("irq_o",       32'(irq),   32'(e.irq));
        chk("irq_ret_o",   32'(ret),   32'(e.ret));
        chk("pending_o",   32'(pend),  32'(e.pend));
        chk("irq_id_o",    32'(id),    32'(e.id));
        chk("irq_cause_o", cause,      e.cause);
      end
    end
  end

  localparam logic [N-1:0] ALL = 16'hFFFF;

  initial begin : driver
    edge_v = EDGE[N-1:0];
    m_reset();
    // reset state
    cycle(0, '0, ALL, 1, 0, 0);
    cycle(0, '0, ALL, 1, 0, 0);
    cycle(1, '0, ALL, 1, 0, 0);
    // level ch3 wins over ch5-edge-free pattern 0x0028 (ch3 level, ch5 edge)
    cycle(1, 16'h0008, ALL, 1, 0, 0);
    cycle(1, 16'h0008, ALL, 1, 0, 0);
    cycle(1, 16'h0008, ALL, 1, 0, 1);
    cycle(1, 16'h0008, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 1);
    cycle(1, 16'h0028, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 1);
    // edge ch5 latched while mie=0, granted once mie rises (may already be pending)
    cycle(1, 16'h0020, ALL, 0, 0, 0);
    cycle(1, 16'h0000, ALL, 0, 0, 0);
    cycle(1, 16'h0000, ALL, 0, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 1);
    cycle(1, 16'h0000, ALL, 1, 0, 0);
    // nested exception inside interrupt handler
    cycle(1, 16'h0001, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 1, 1);
    cycle(1, 16'h0000, ALL, 1, 0, 1);
    cycle(1, 16'h0000, ALL, 1, 0, 1);
    cycle(1, 16'h0000, ALL, 1, 0, 0);
    // exception beats a pending interrupt; edge ch7 latched during EXC
    cycle(1, 16'h0001, ALL, 1, 1, 0);
    cycle(1, 16'h0081, ALL, 1, 1, 0);
    cycle(1, 16'h0001, ALL, 1, 0, 0);
    cycle(1, 16'h0001, ALL, 1, 0, 1);
    cycle(1, 16'h0001, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 1);
    cycle(1, 16'h0000, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 1);
    // channel 15 boundary, masked channel ignored
    cycle(1, 16'h8000, 16'h7FFF, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 1);
    // async reset mid-IRQ with a latched edge outstanding
    cycle(1, 16'h0008, ALL, 1, 0, 0);
    cycle(1, 16'h1008, ALL, 1, 0, 0);
    cycle(0, 16'h1008, ALL, 1, 0, 0);
    cycle(0, 16'h0008, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 0);
    cycle(1, 16'h0000, ALL, 1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] rq, mk;
      rq = N'($urandom) & N'($urandom);
      mk = ($urandom_range(0, 3) == 0) ? N'($urandom) : ALL;
      cycle(($urandom_range(0, 99) != 0), rq, mk, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
    end
    begin : drain
      int waited;
      waited = 0;
      while (sb.size() > 0 && waited < 20) begin
        @(posedge clk);
        waited++;
      end
      if (sb.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
